// File: rtl/wb_sram_student_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge.
// Holds the FSM state encoding, default access timings and pin widths,
// plus a small max() helper used to size the wait counter.
package wb_sram_student_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WPULSE  = 3'd2,
    S_WHOLD   = 3'd3,
    S_RWAIT   = 3'd4,
    S_ACK     = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WE_CYCLES  = 2;
  localparam int DEF_RD_CYCLES  = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_sram_student.sv
// Wishbone B4 classic student serving single byte reads/writes on an
// external async SRAM (1Mx8).
// Bus side : CLK_I, RST_I (sync, active-low), CYC_I, STB_I, WE_I, ADR_I,
//            DAT_I, SEL_I, LOCK_I/TGA_I/TGD_I/TGC_I (ignored),
//            DAT_O, ACK_O, ERR_O, RTY_O (tied 0).
// Chip side: o_addr, io_c_data (tristate), o_n_oe, o_n_we (active-low).
module wb_sram_student
  import wb_sram_student_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ATAG_WIDTH = 2,
  parameter int DTAG_WIDTH = 2,
  parameter int CTAG_WIDTH = 2,
  parameter int WE_CYCLES  = DEF_WE_CYCLES,
  parameter int RD_CYCLES  = DEF_RD_CYCLES
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [ADDR_WIDTH-1:0] ADR_I,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic                  SEL_I,
  input  logic                  LOCK_I,
  input  logic [ATAG_WIDTH-1:0] TGA_I,
  input  logic [DTAG_WIDTH-1:0] TGD_I,
  input  logic [CTAG_WIDTH-1:0] TGC_I,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic                  ACK_O,
  output logic                  ERR_O,
  output logic                  RTY_O,
  output logic [ADDR_WIDTH-1:0] o_addr,
  inout  wire  [DATA_WIDTH-1:0] io_c_data,
  output logic                  o_n_oe,
  output logic                  o_n_we
);

  localparam int CW = $clog2(max2(WE_CYCLES, RD_CYCLES) + 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  we_q, we_n;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  req, accept;

  assign req    = CYC_I & STB_I;
  assign accept = (state == S_IDLE) & req & SEL_I;
  // direction of the access as it will be after this edge, so the
  // registered o_n_oe is already correct in the SETUP clock
  assign we_n   = accept ? WE_I : we_q;
  assign RTY_O  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{LOCK_I, TGA_I, TGD_I, TGC_I};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE:    if (req) state_n = SEL_I ? S_SETUP : S_RELEASE;
      S_SETUP: begin
        cnt_n   = we_q ? CW'(WE_CYCLES - 1) : CW'(RD_CYCLES - 1);
        state_n = we_q ? S_WPULSE : S_RWAIT;
      end
      S_WPULSE:  if (cnt == '0) state_n = S_WHOLD; else cnt_n = cnt - 1'b1;
      S_WHOLD:   state_n = S_ACK;
      S_RWAIT:   if (cnt == '0) state_n = S_ACK; else cnt_n = cnt - 1'b1;
      S_ACK:     state_n = S_RELEASE;
      // a strobe held after the acknowledge must not start a new access
      S_RELEASE: if (!STB_I) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state  <= S_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      wdata  <= '0;
      DAT_O  <= '0;
      ACK_O  <= 1'b0;
      ERR_O  <= 1'b0;
      o_addr <= '0;
      o_n_oe <= 1'b1;
      o_n_we <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      we_q   <= we_n;
      if (accept) begin
        o_addr <= ADR_I;
        wdata  <= DAT_I;
      end
      if (state == S_RWAIT && cnt == '0) DAT_O <= io_c_data;
      // acknowledge only if the mentor is still waiting for it
      ACK_O  <= (state_n == S_ACK) & req;
      ERR_O  <= (state == S_IDLE) & req & ~SEL_I;
      o_n_we <= ~(state_n == S_WPULSE);
      o_n_oe <= ~(~we_n & ((state_n == S_SETUP) | (state_n == S_RWAIT)));
    end
  end

  // only a write's SETUP/WPULSE/WHOLD drives the pins; reads leave them to the chip
  assign io_c_data = (we_q && (state == S_SETUP || state == S_WPULSE || state == S_WHOLD))
                     ? wdata : {DATA_WIDTH{1'bz}};

endmodule
